// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter that shares one combinational FP_ALU between two requesters.
// Define FP_ARB_ERR_EN to reject op 2'b11 with resp_err instead of issuing it to the ALU.
module fp_alu_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,

    output logic [WIDTH-1:0] alu_para1,
    output logic [WIDTH-1:0] alu_para2,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_uo,
    input  logic             alu_zero,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_uo,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             busy
);

    // state   | meaning
    // IDLE    | waiting for a request; ready offered to the round-robin winner
    // EXEC    | ALU inputs held while the settle counter runs down
    // RESP    | captured result presented until the consumer accepts it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_para1_q, alu_para1_d;
    logic [WIDTH-1:0] alu_para2_q, alu_para2_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_uo_q, resp_uo_d;
    logic             resp_zero_q, resp_zero_d;
    logic             busy_q, busy_d;

    logic             any_valid;
    logic             grant;
    logic             winner;
    logic             take_err;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [1:0]       win_op;

    // On contention the requester that did not win last time goes first.
    assign any_valid  = req0_valid | req1_valid;
    assign winner     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign grant      = rst_n & (state_q == ST_IDLE) & any_valid;
    assign req0_ready = grant & ~winner;
    assign req1_ready = grant & winner;

    assign win_a  = winner ? req1_a  : req0_a;
    assign win_b  = winner ? req1_b  : req0_b;
    assign win_op = winner ? req1_op : req0_op;

`ifdef FP_ARB_ERR_EN
    logic resp_err_q, resp_err_d;
    assign take_err = (win_op == 2'b11);
    assign resp_err = resp_err_q;
`else
    assign take_err = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_para1_d  = alu_para1_q;
        alu_para2_d  = alu_para2_q;
        alu_op_d     = alu_op_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_uo_d    = resp_uo_q;
        resp_zero_d  = resp_zero_q;
`ifdef FP_ARB_ERR_EN
        resp_err_d   = resp_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    last_grant_d = winner;
                    resp_id_d    = winner;
`ifdef FP_ARB_ERR_EN
                    resp_err_d   = take_err;
`endif
                    // Illegal ops never reach the ALU; the ALU keeps its previous inputs.
                    if (take_err) begin
                        resp_data_d  = '0;
                        resp_uo_d    = 1'b0;
                        resp_zero_d  = 1'b0;
                        resp_valid_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        alu_para1_d = win_a;
                        alu_para2_d = win_b;
                        alu_op_d    = win_op;
                        cnt_d       = CNT_LOAD;
                        state_d     = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    resp_data_d  = alu_out;
                    resp_uo_d    = alu_uo;
                    resp_zero_d  = alu_zero;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            alu_para1_q  <= '0;
            alu_para2_q  <= '0;
            alu_op_q     <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_uo_q    <= 1'b0;
            resp_zero_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef FP_ARB_ERR_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_para1_q  <= alu_para1_d;
            alu_para2_q  <= alu_para2_d;
            alu_op_q     <= alu_op_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_uo_q    <= resp_uo_d;
            resp_zero_q  <= resp_zero_d;
            busy_q       <= busy_d;
`ifdef FP_ARB_ERR_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign alu_para1  = alu_para1_q;
    assign alu_para2  = alu_para2_q;
    assign alu_op     = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_uo    = resp_uo_q;
    assign resp_zero  = resp_zero_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Bench for fp_alu_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_fp_alu_arbiter;
    localparam int W = 32;
    localparam int S = 1;
`ifdef FP_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] alu_para1, alu_para2, alu_out;
    logic [1:0]   alu_op;
    logic         alu_uo, alu_zero;
    logic         resp_valid, resp_ready, resp_id, resp_uo, resp_zero, resp_err, busy;
    logic [W-1:0] resp_data;

    fp_alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_para1(alu_para1), .alu_para2(alu_para2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_uo(alu_uo), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_uo(resp_uo), .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for FP_ALU: 1.0+2.0 gives real IEEE 3.0, everything else uses integer arithmetic.
    function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [31:0] d;
        logic        uo;
        uo = 1'b0;
        case (op)
            2'b00:   d = (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
            2'b01:   d = a - b;
            2'b10:   begin d = a * b; uo = a[30] & b[30]; end
            default: d = 32'h0;
        endcase
        return {uo, (d == 32'h0), d};
    endfunction

    assign {alu_uo, alu_zero, alu_out} = ref_alu(alu_para1, alu_para2, alu_op);

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } op_t;

    op_t q0[$];
    op_t q1[$];

    task automatic push(input bit who, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        op_t t;
        t.a = a; t.b = b; t.op = op;
        if (who) q1.push_back(t);
        else     q0.push_back(t);
    endtask

    // Requesters: present the queue head, hold it until accepted.
    initial begin
        bit acc0, acc1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
        forever begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0 && q0.size() > 0) q0.delete(0);
            if (acc1 && q1.size() > 0) q1.delete(0);
            if (q0.size() > 0) begin
                req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op;
            end else begin
                req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
            end
            if (q1.size() > 0) begin
                req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op;
            end else begin
                req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
            end
        end
    end

    // Observed events, used by the directed checks.
    int          g_id[$];
    int          g_cyc[$];
    int          r_id[$];
    int          r_cyc[$];
    logic [31:0] r_data[$];
    bit          r_zero[$];
    bit          r_err[$];
    int          a_cyc[$];
    bit          rv_prev = 1'b0;

    // Transaction-level model: one op outstanding, due a fixed number of cycles after its grant.
    bit          m_known = 1'b0;
    bit          m_free, m_last, m_pend, m_id, m_uo, m_zero, m_err;
    logic [31:0] m_data, m_a, m_b;
    logic [1:0]  m_op;
    int          m_due;

    always @(negedge clk) begin
        bit          e_r0, e_r1, e_rv, w, e_err;
        logic [33:0] res;
        logic [31:0] pa, pb;
        logic [1:0]  po;

        if (req0_valid && req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); end
        if (req1_valid && req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); end
        if (resp_valid && !rv_prev) begin
            r_id.push_back(int'(resp_id)); r_cyc.push_back(cyc);
            r_data.push_back(resp_data); r_zero.push_back(resp_zero); r_err.push_back(resp_err);
        end
        if (resp_valid && resp_ready) a_cyc.push_back(cyc);
        rv_prev = resp_valid;

        e_r0 = rst_n && m_free && req0_valid && (!req1_valid || m_last);
        e_r1 = rst_n && m_free && req1_valid && (!req0_valid || !m_last);
        e_rv = m_pend && (cyc >= m_due);

        if (m_known) begin
            chk("req0_ready", 64'(req0_ready), 64'(e_r0));
            chk("req1_ready", 64'(req1_ready), 64'(e_r1));
            chk("busy", 64'(busy), 64'(!m_free));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv));
            chk("alu_para1", 64'(alu_para1), 64'(m_a));
            chk("alu_para2", 64'(alu_para2), 64'(m_b));
            chk("alu_op", 64'(alu_op), 64'(m_op));
            if (!ERR_EN) chk("resp_err_tied", 64'(resp_err), 64'd0);
            if (e_rv) begin
                chk("resp_id", 64'(resp_id), 64'(m_id));
                chk("resp_data", 64'(resp_data), 64'(m_data));
                chk("resp_uo", 64'(resp_uo), 64'(m_uo));
                chk("resp_zero", 64'(resp_zero), 64'(m_zero));
                chk("resp_err", 64'(resp_err), 64'(m_err));
            end
        end

        if (!rst_n) begin
            m_known = 1'b1; m_free = 1'b1; m_last = 1'b1; m_pend = 1'b0;
            m_a = '0; m_b = '0; m_op = 2'b00;
        end else if (m_known) begin
            if (e_rv && resp_ready) begin
                m_pend = 1'b0;
                m_free = 1'b1;
            end else if (e_r0 || e_r1) begin
                w  = e_r1;
                pa = w ? req1_a : req0_a;
                pb = w ? req1_b : req0_b;
                po = w ? req1_op : req0_op;
                e_err  = ERR_EN && (po == 2'b11);
                m_last = w; m_id = w; m_pend = 1'b1; m_free = 1'b0; m_err = e_err;
                if (e_err) begin
                    m_data = '0; m_uo = 1'b0; m_zero = 1'b0;
                    m_due  = cyc + 1;
                end else begin
                    res    = ref_alu(pa, pb, po);
                    m_uo   = res[33]; m_zero = res[32]; m_data = res[31:0];
                    m_a    = pa; m_b = pb; m_op = po;
                    m_due  = cyc + 1 + S;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int n, input int limit);
        int k = 0;
        while (r_id.size() < n && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_resp_count", 64'(r_id.size() >= n), 64'd1);
    endtask

    task automatic wait_grants(input int n, input int limit);
        int k = 0;
        while (g_id.size() < n && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_grant_count", 64'(g_id.size() >= n), 64'd1);
    endtask

    function automatic int gi_at(input int i);
        return (i < g_id.size()) ? g_id[i] : -1;
    endfunction
    function automatic int gc_at(input int i);
        return (i < g_cyc.size()) ? g_cyc[i] : -1000;
    endfunction
    function automatic int ri_at(input int i);
        return (i < r_id.size()) ? r_id[i] : -1;
    endfunction
    function automatic int rc_at(input int i);
        return (i < r_cyc.size()) ? r_cyc[i] : -1000;
    endfunction
    function automatic int ac_at(input int i);
        return (i < a_cyc.size()) ? a_cyc[i] : -1000;
    endfunction

    initial begin
        int gi, ri, ai;
        rst_n = 1'b0;
        resp_ready = 1'b1;

        // Reset
        repeat (2) tick();
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_para1", 64'(alu_para1), 64'd0);
        chk("rst_alu_para2", 64'(alu_para2), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_flags", 64'({resp_uo, resp_zero, resp_err}), 64'd0);
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        rst_n = 1'b1;
        push(1'b1, 32'h1, 32'h2, 2'b00);
        wait_resp(1, 50);
        chk("t1_grant_id", 64'(gi_at(0)), 64'd1);
        chk("t1_resp_id", 64'(ri_at(0)), 64'd1);
        chk("t1_resp_data", 64'(r_data.size() > 0 ? r_data[0] : 32'hdead), 64'h3);

        // Contention: both requesters valid for two ops each
        gi = g_id.size(); ri = r_id.size();
        push(1'b0, 32'd10, 32'd3, 2'b01);
        push(1'b0, 32'd6,  32'd7, 2'b10);
        push(1'b1, 32'd4,  32'd4, 2'b01);
        push(1'b1, 32'd9,  32'd1, 2'b00);
        wait_resp(ri + 4, 100);
        for (int k = 0; k < 4; k++) begin
            chk("t3_grant_order", 64'(gi_at(gi + k)), 64'(k % 2));
            chk("t3_resp_order", 64'(ri_at(ri + k)), 64'(k % 2));
        end
        for (int k = 1; k < 4; k++)
            chk("t3_grant_spacing", 64'(gc_at(gi + k) - gc_at(gi + k - 1)), 64'd3);

        // Single add, 1.0 + 2.0
        gi = g_id.size(); ri = r_id.size();
        push(1'b0, 32'h3F800000, 32'h40000000, 2'b00);
        wait_resp(ri + 1, 50);
        chk("t2_grant_id", 64'(gi_at(gi)), 64'd0);
        chk("t2_latency", 64'(rc_at(ri) - gc_at(gi)), 64'd2);
        chk("t2_resp_data", 64'(r_data.size() > ri ? r_data[ri] : 32'hdead), 64'h40400000);
        chk("t2_resp_zero", 64'(r_zero.size() > ri ? r_zero[ri] : 1'b1), 64'd0);
        chk("t2_resp_id", 64'(ri_at(ri)), 64'd0);

        // Backpressure: response held for five cycles
        tick();
        resp_ready = 1'b0;
        gi = g_id.size(); ri = r_id.size(); ai = a_cyc.size();
        push(1'b0, 32'd100, 32'd1, 2'b01);
        push(1'b1, 32'd5,   32'd5, 2'b01);
        wait_resp(ri + 1, 50);
        repeat (5) tick();
        resp_ready = 1'b1;
        wait_grants(gi + 2, 50);
        chk("t4_hold_cycles", 64'(ac_at(ai) - rc_at(ri)), 64'd5);
        chk("t4_regrant_delay", 64'(gc_at(gi + 1) - ac_at(ai)), 64'd1);
        chk("t4_first_id", 64'(gi_at(gi)), 64'd1);
        chk("t4_second_id", 64'(gi_at(gi + 1)), 64'd0);
        wait_resp(ri + 2, 50);

        // Reset while an op is executing
        tick();
        gi = g_id.size(); ri = r_id.size();
        push(1'b1, 32'd77, 32'd11, 2'b00);
        wait_grants(gi + 1, 50);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy_after_rst", 64'(busy), 64'd0);
        chk("t5_resp_valid_after_rst", 64'(resp_valid), 64'd0);
        repeat (3) tick();
        chk("t5_op_lost", 64'(r_id.size()), 64'(ri));
        push(1'b0, 32'd20, 32'd2, 2'b10);
        push(1'b1, 32'd30, 32'd3, 2'b01);
        wait_resp(ri + 2, 100);
        chk("t5_first_after_rst", 64'(gi_at(gi + 1)), 64'd0);
        chk("t5_resp_order", 64'(ri_at(ri)), 64'd0);

        // Op 2'b11
        tick();
        gi = g_id.size(); ri = r_id.size();
        push(1'b1, 32'h12345678, 32'h9ABCDEF0, 2'b11);
        wait_resp(ri + 1, 50);
        if (ERR_EN) begin
            chk("t6_err_latency", 64'(rc_at(ri) - gc_at(gi)), 64'd1);
            chk("t6_err_flag", 64'(r_err.size() > ri ? r_err[ri] : 1'b0), 64'd1);
            chk("t6_err_data", 64'(r_data.size() > ri ? r_data[ri] : 32'hdead), 64'd0);
        end else begin
            chk("t6_latency", 64'(rc_at(ri) - gc_at(gi)), 64'd2);
            chk("t6_data", 64'(r_data.size() > ri ? r_data[ri] : 32'hdead), 64'd0);
            chk("t6_zero", 64'(r_zero.size() > ri ? r_zero[ri] : 1'b0), 64'd1);
            chk("t6_err_flag", 64'(r_err.size() > ri ? r_err[ri] : 1'b1), 64'd0);
        end
        push(1'b0, 32'd5, 32'd7, 2'b10);
        wait_resp(ri + 2, 50);
        chk("t6_next_err_clear", 64'(r_err.size() > ri + 1 ? r_err[ri + 1] : 1'b1), 64'd0);
        chk("t6_next_data", 64'(r_data.size() > ri + 1 ? r_data[ri + 1] : 32'hdead), 64'h23);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion before %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
